// File: rtl/pakin_arb_if.sv
// Purpose: requester-side and link-side 4-phase packet channels plus grant status of pakin_arb.
// Latency: none; this file only bundles wires.
// Backpressure: the req/ack pairs carry it; there are no valid/ready signals in this bundle.
//
// master: the arbiter side. It drives rq_ack, lnk_req, lnk_pkt, grant_vld and grant_idx.
// slave:  the side made up of the requesters and pakin. It drives rq_req, rq_pkt and lnk_ack.
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 8
`endif
`ifndef NS_FULL_MSG_SZ
`define NS_FULL_MSG_SZ 16
`endif

interface pakin_arb_if #(
    parameter int NREQ = 2,
    parameter int PSZ  = `NS_PACKET_SIZE
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]     rq_req;
    logic [NREQ-1:0]     rq_ack;
    logic [NREQ*PSZ-1:0] rq_pkt;
    logic                lnk_req;
    logic                lnk_ack;
    logic [PSZ-1:0]      lnk_pkt;
    logic                grant_vld;
    logic [IW-1:0]       grant_idx;

    modport master (
        input  rq_req, rq_pkt, lnk_ack,
        output rq_ack, lnk_req, lnk_pkt, grant_vld, grant_idx
    );

    modport slave (
        output rq_req, rq_pkt, lnk_ack,
        input  rq_ack, lnk_req, lnk_pkt, grant_vld, grant_idx
    );
endinterface

// File: rtl/pakin_arb.sv
// Purpose: round-robin arbiter that shares one pakin packet link among NREQ senders, and holds each grant for a whole message.
// Latency: 2 cycles from a request seen in IDLE to lnk_req; 1 cycle from rq_req to lnk_req inside a message; 1 cycle from lnk_ack to rq_ack.
// Backpressure: 4-phase req/ack handshake. A sender stalls until pakin acks its packet, and other senders wait until the current message completes.
//
// Ports: gch_clk is the clock. gch_reset is an asynchronous active-low reset.
//        gch_ready goes high one cycle after reset is released.
//        bus (master modport) carries the per-requester rq_req, rq_ack and rq_pkt,
//        the shared link lnk_req, lnk_ack and lnk_pkt, and the grant_vld and grant_idx status.
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 8
`endif
`ifndef NS_FULL_MSG_SZ
`define NS_FULL_MSG_SZ 16
`endif

module pakin_arb #(
    parameter int NREQ    = 2,
    parameter int PSZ     = `NS_PACKET_SIZE,
    parameter int TOT_PKS = ((`NS_FULL_MSG_SZ / `NS_PACKET_SIZE) + 1),
    parameter int CW      = $clog2(TOT_PKS + 1)
) (
    input  logic         gch_clk,
    input  logic         gch_reset,
    output logic         gch_ready,
    pakin_arb_if.master  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ARM,
        S_WAIT_ACK,
        S_WAIT_REL
    } state_t;

    state_t          state;
    logic            ready_q;
    logic [NREQ-1:0] ack_q;
    logic            lreq_q;
    logic [PSZ-1:0]  lpkt_q;
    logic            gvld_q;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;

    assign cnt_nxt = cnt + CW'(1);

    // Rotating-priority pick. The scan runs from the farthest offset down to
    // the nearest, so the last hit is the requester closest after rr_ptr.
    // The requester granted last therefore has the lowest priority.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (bus.rq_req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(idx);
            end
        end
    end

    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            state   <= S_INIT;
            ready_q <= 1'b0;
            ack_q   <= '0;
            lreq_q  <= 1'b0;
            lpkt_q  <= '0;
            gvld_q  <= 1'b0;
            gidx    <= '0;
            cnt     <= '0;
            rr_ptr  <= IW'(NREQ - 1);
        end else begin
            case (state)
                S_INIT: begin
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
                S_IDLE: begin
                    if (pick_vld) begin
                        gidx   <= pick_idx;
                        gvld_q <= 1'b1;
                        cnt    <= '0;
                        state  <= S_ARM;
                    end
                end
                // Only the owner is looked at. Other senders keep waiting with rq_ack low.
                S_ARM: begin
                    if (bus.rq_req[gidx]) begin
                        lpkt_q <= bus.rq_pkt[int'(gidx)*PSZ +: PSZ];
                        lreq_q <= 1'b1;
                        state  <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (bus.lnk_ack) begin
                        ack_q[gidx] <= 1'b1;
                        lreq_q      <= 1'b0;
                        state       <= S_WAIT_REL;
                    end
                end
                // Both sides must return to zero before the next packet.
                // This keeps lnk_pkt stable until pakin drops its ack.
                S_WAIT_REL: begin
                    if (!bus.rq_req[gidx] && !bus.lnk_ack) begin
                        ack_q[gidx] <= 1'b0;
                        cnt         <= cnt_nxt;
                        if (cnt_nxt == CW'(TOT_PKS)) begin
                            rr_ptr <= gidx;
                            gvld_q <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_ARM;
                        end
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign gch_ready     = ready_q;
    assign bus.rq_ack    = ack_q;
    assign bus.lnk_req   = lreq_q;
    assign bus.lnk_pkt   = lpkt_q;
    assign bus.grant_vld = gvld_q;
    assign bus.grant_idx = gidx;
endmodule

// File: tb/tb_pakin_arb.sv
// Purpose: randomized and directed bench for pakin_arb with an owner/round-robin reference model.
// Latency: not applicable.
// Backpressure: the pakin emulator acks after random delays and can hold off its ack entirely.
module tb_pakin_arb;
    localparam int NREQ = 2;
    localparam int PSZ  = 8;
    localparam int TOT  = 3;
    localparam int TMO  = 400;

    logic gch_clk   = 1'b0;
    logic gch_reset = 1'b1;
    logic gch_ready;

    pakin_arb_if #(.NREQ(NREQ), .PSZ(PSZ)) bus ();

    pakin_arb #(.NREQ(NREQ), .PSZ(PSZ), .TOT_PKS(TOT)) u_dut (
        .gch_clk   (gch_clk),
        .gch_reset (gch_reset),
        .gch_ready (gch_ready),
        .bus       (bus)
    );

    always #5 gch_clk = ~gch_clk;

    int checks = 0;
    int errors = 0;
    bit pk_hold = 1'b0;

    // Packets seen on the link as {owner, payload}, and grant owners in order.
    logic [15:0] dut_log[$];
    int          glog[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic to_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no response, required one within %0d cycles at %0t", nm, TMO, $time);
    endtask

    task automatic check_log(input string nm, input logic [15:0] exp_q[$]);
        chk({nm, "_len"}, dut_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k < dut_log.size()) chk($sformatf("%s_%0d", nm, k), dut_log[k], exp_q[k]);
    endtask

    task automatic check_glog(input string nm, input int exp_q[$]);
        chk({nm, "_len"}, glog.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k < glog.size()) chk($sformatf("%s_%0d", nm, k), glog[k], exp_q[k]);
    endtask

    // ---------------- pakin emulator ----------------
    initial begin
        bus.lnk_ack = 1'b0;
        forever begin
            @(posedge gch_clk); #1;
            if (!gch_reset) bus.lnk_ack = 1'b0;
            else if (bus.lnk_req && !bus.lnk_ack && !pk_hold && ($urandom_range(0, 2) != 0)) bus.lnk_ack = 1'b1;
            else if (!bus.lnk_req && bus.lnk_ack && ($urandom_range(0, 2) != 0)) bus.lnk_ack = 1'b0;
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    // The model keeps only the owner, the packets done in the message, and
    // the last-granted pointer. The expected handshake outputs follow from
    // the inputs the bench drove and the model's own previous expectations.
    int              stage, own, rr, cnt;
    bit              own_vld;
    logic [PSZ-1:0]  m_pkt;
    logic [NREQ-1:0] p_req, p_ack, e_ack;
    logic [NREQ*PSZ-1:0] p_pkt;
    bit              p_lreq, p_lack, e_lreq;
    bit              d_lreq_q, d_gv_q;

    always @(negedge gch_clk) begin
        if (!gch_reset) begin
            stage = 0; own_vld = 0; own = 0; rr = NREQ - 1; cnt = 0;
            m_pkt = '0; e_lreq = 0; e_ack = '0;
            chk("rst_ready", gch_ready, 0);
            chk("rst_rq_ack", bus.rq_ack, 0);
            chk("rst_lnk_req", bus.lnk_req, 0);
            chk("rst_lnk_pkt", bus.lnk_pkt, 0);
            chk("rst_grant_vld", bus.grant_vld, 0);
            chk("rst_grant_idx", bus.grant_idx, 0);
        end else begin
            e_lreq = 0;
            e_ack  = '0;
            if (stage == 2) begin
                if (!own_vld) begin
                    for (int k = 1; k <= NREQ; k++)
                        if (!own_vld && p_req[(rr + k) % NREQ]) begin
                            own_vld = 1; own = (rr + k) % NREQ; cnt = 0;
                        end
                end else if (p_lreq) begin
                    if (p_lack) e_ack[own] = 1'b1;
                    else        e_lreq = 1;
                end else if (p_ack[own]) begin
                    if (!p_req[own] && !p_lack) begin
                        cnt++;
                        if (cnt == TOT) begin own_vld = 0; rr = own; end
                    end else e_ack[own] = 1'b1;
                end else if (p_req[own]) begin
                    e_lreq = 1;
                    m_pkt  = p_pkt[own*PSZ +: PSZ];
                end
            end
            chk("ready", gch_ready, (stage != 0));
            chk("grant_vld", bus.grant_vld, own_vld);
            if (own_vld) chk("grant_idx", bus.grant_idx, own);
            chk("lnk_req", bus.lnk_req, e_lreq);
            chk("rq_ack", bus.rq_ack, e_ack);
            chk("lnk_pkt", bus.lnk_pkt, m_pkt);
            if (stage < 2) stage++;

            if (bus.lnk_req && !d_lreq_q) dut_log.push_back({8'(bus.grant_idx), bus.lnk_pkt});
            if (bus.grant_vld && !d_gv_q) glog.push_back(int'(bus.grant_idx));
        end
        p_req = bus.rq_req; p_lack = bus.lnk_ack; p_pkt = bus.rq_pkt;
        p_lreq = e_lreq; p_ack = e_ack;
        d_lreq_q = bus.lnk_req; d_gv_q = bus.grant_vld;
    end

    // ---------------- requester side ----------------
    task automatic send_pkt(input int i, input logic [PSZ-1:0] v, input int gap);
        int t;
        repeat (gap) @(posedge gch_clk);
        @(posedge gch_clk); #1;
        bus.rq_pkt[i*PSZ +: PSZ] = v;
        bus.rq_req[i] = 1'b1;
        t = 0;
        while (bus.rq_ack[i] !== 1'b1 && t < TMO) begin @(posedge gch_clk); #1; t++; end
        if (t >= TMO) to_fail($sformatf("ack_rise_req%0d", i));
        repeat ($urandom_range(0, 1)) begin @(posedge gch_clk); #1; end
        bus.rq_req[i] = 1'b0;
        t = 0;
        while (bus.rq_ack[i] !== 1'b0 && t < TMO) begin @(posedge gch_clk); #1; t++; end
        if (t >= TMO) to_fail($sformatf("ack_fall_req%0d", i));
    endtask

    task automatic send_msg(input int i, input logic [PSZ-1:0] base, input int maxgap, input int first_gap);
        for (int p = 0; p < TOT; p++)
            send_pkt(i, base + PSZ'(p), (p == 0) ? first_gap : int'($urandom_range(0, maxgap)));
    endtask

    task automatic do_reset();
        @(posedge gch_clk); #2;
        gch_reset = 1'b0;
        repeat (2) @(posedge gch_clk);
        #1 gch_reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        bus.rq_req = '0;
        bus.rq_pkt = '0;
        #1 gch_reset = 1'b0;
        repeat (3) @(posedge gch_clk);
        #1;
        chk("t1_ready_in_reset", gch_ready, 0);
        chk("t1_lnk_req_in_reset", bus.lnk_req, 0);
        gch_reset = 1'b1;
        #1 chk("t1_ready_at_release", gch_ready, 0);
        @(posedge gch_clk); #1;
        chk("t1_ready_after_1cyc", gch_ready, 1);
        chk("t1_rq_ack_idle", bus.rq_ack, 0);

        // Requester 0 alone sends one full message.
        dut_log.delete(); glog.delete();
        send_pkt(0, 8'hA1, 0);
        send_pkt(0, 8'hA2, 1);
        send_pkt(0, 8'hA3, 0);
        repeat (3) @(posedge gch_clk);
        check_log("t2_log", '{16'h00A1, 16'h00A2, 16'h00A3});
        check_glog("t2_grants", '{0});

        // Simultaneous requests right after reset: requester 0 wins, and the message is not interleaved.
        do_reset();
        dut_log.delete(); glog.delete();
        fork
            send_msg(0, 8'hB1, 0, 0);
            send_msg(1, 8'hC1, 0, 0);
        join
        repeat (3) @(posedge gch_clk);
        check_log("t3_log", '{16'h00B1, 16'h00B2, 16'h00B3, 16'h01C1, 16'h01C2, 16'h01C3});
        check_glog("t3_grants", '{0, 1});

        // Requester 1 arrives in the middle of requester 0's message.
        dut_log.delete(); glog.delete();
        fork
            send_msg(0, 8'hD1, 2, 0);
            begin
                t = 0;
                while (bus.rq_ack[0] !== 1'b1 && t < TMO) begin @(posedge gch_clk); #1; t++; end
                if (t >= TMO) to_fail("t4_wait_ack0");
                send_msg(1, 8'hE1, 0, 0);
            end
        join
        repeat (3) @(posedge gch_clk);
        check_log("t4_log", '{16'h00D1, 16'h00D2, 16'h00D3, 16'h01E1, 16'h01E2, 16'h01E3});

        // Continuous traffic from both requesters: ownership alternates per message.
        glog.delete();
        fork
            for (int m = 0; m < 3; m++) send_msg(0, PSZ'($urandom), 2, (m == 0) ? 0 : int'($urandom_range(0, 2)));
            for (int m = 0; m < 3; m++) send_msg(1, PSZ'($urandom), 2, (m == 0) ? 0 : int'($urandom_range(0, 2)));
        join
        repeat (3) @(posedge gch_clk);
        check_glog("t5_grants", '{0, 1, 0, 1, 0, 1});

        // Reset while in WAIT_ACK. Requester 1 holds the grant, with requester 0 granted last.
        send_msg(0, 8'h71, 1, 0);
        pk_hold = 1'b1;
        @(posedge gch_clk); #1;
        bus.rq_pkt[PSZ +: PSZ] = 8'h5A;
        bus.rq_req[1] = 1'b1;
        t = 0;
        while (!bus.lnk_req && t < 20) begin @(posedge gch_clk); #1; t++; end
        if (t >= 20) to_fail("t6_lnk_req");
        chk("t6_pre_grant_idx", bus.grant_idx, 1);
        chk("t6_pre_lnk_pkt", bus.lnk_pkt, 8'h5A);
        #1 gch_reset = 1'b0;
        #1;
        chk("t6_async_lnk_req", bus.lnk_req, 0);
        chk("t6_async_grant_vld", bus.grant_vld, 0);
        chk("t6_async_rq_ack", bus.rq_ack, 0);
        chk("t6_async_ready", gch_ready, 0);
        bus.rq_req = '0;
        pk_hold = 1'b0;
        repeat (2) @(posedge gch_clk);
        #1 gch_reset = 1'b1;
        glog.delete();
        fork
            send_msg(1, 8'h91, 0, 0);
            send_msg(0, 8'h81, 0, 0);
        join
        repeat (3) @(posedge gch_clk);
        check_glog("t6_grants", '{0, 1});

        // Random traffic, checked cycle by cycle by the model.
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0)
                send_msg(int'($urandom_range(0, NREQ - 1)), PSZ'($urandom), 3, int'($urandom_range(0, 4)));
            else
                fork
                    send_msg(0, PSZ'($urandom), 3, int'($urandom_range(0, 6)));
                    send_msg(1, PSZ'($urandom), 3, int'($urandom_range(0, 6)));
                join
        end

        repeat (5) @(posedge gch_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pakin_arb.md
Name: pakin_arb

Overview:
- Round-robin arbiter that shares one packet-input link between NREQ packet senders.
- The shared link is a 4-phase req/ack packet channel whose consumer is the pakin packet receiver.
- A grant is held for a whole message (TOT_PKS packets), so packets from different senders never interleave inside a message.
- Sits between the packet-out stages of several cells and a single pakin instance.

Parameters:
- NREQ, 2, number of requesting packet channels (2..8).
- PSZ, `NS_PACKET_SIZE, packet payload width in bits.
- TOT_PKS, ((`NS_FULL_MSG_SZ / `NS_PACKET_SIZE) + 1), packets per message (>=1).
- CW, $clog2(TOT_PKS+1), packet counter width.

Ports:
- gch_clk  in  1  system clock; all state changes on the rising edge.
- gch_reset  in  1  asynchronous, active-low reset.
- gch_ready  out  1  high once the arbiter is initialised and able to accept requests.
- rq_req  in  NREQ  per-requester packet request (bit i = requester i).
- rq_ack  out  NREQ  per-requester packet acknowledge.
- rq_pkt  in  NREQ*PSZ  requester packets; requester i occupies bits [i*PSZ +: PSZ].
- lnk_req  out  1  request on the shared link toward pakin.
- lnk_ack  in  1  acknowledge from pakin.
- lnk_pkt  out  PSZ  registered packet on the shared link.
- grant_vld  out  1  high while a requester owns the link (states ARM, WAIT_ACK, WAIT_REL).
- grant_idx  out  $clog2(NREQ) (min 1)  index of the owning requester; valid only when grant_vld is high.

Behaviour:
- Reset (gch_reset low, asynchronous): all outputs and registers cleared.
  - gch_ready=0, rq_ack=0, lnk_req=0, lnk_pkt=0, grant_vld=0, grant_idx=0.
  - State goes to INIT; cnt=0; rr_ptr=NREQ-1, so requester 0 has first priority.
- INIT: one cycle after reset is released, go to IDLE and set gch_ready=1. gch_ready stays 1 until the next reset.
- IDLE:
  - If any rq_req bit is high, pick the first requester found scanning from rr_ptr+1 upward, with modulo-NREQ wrap.
  - Load grant_idx with that requester, set grant_vld=1, clear cnt, go to ARM.
  - If no request is pending, stay in IDLE.
- ARM: wait for rq_req[g]=1 from the granted requester g. Then:
  - lnk_pkt <= rq_pkt[g], lnk_req <= 1, go to WAIT_ACK.
  - Requests from other requesters are ignored; their rq_ack stays 0.
- WAIT_ACK: when lnk_ack=1, set rq_ack[g] <= 1 and lnk_req <= 0, go to WAIT_REL.
- WAIT_REL: when rq_req[g]=0 and lnk_ack=0 in the same cycle, set rq_ack[g] <= 0 and cnt <= cnt+1. Then:
  - If cnt+1 == TOT_PKS: rr_ptr <= g, grant_vld <= 0, go to IDLE.
  - Otherwise go to ARM.
- Latency:
  - Request seen in IDLE to lnk_req high: 2 cycles (IDLE->ARM, ARM->WAIT_ACK).
  - Inside a message: 1 cycle from rq_req[g] rising in ARM to lnk_req high.
  - lnk_ack rising to rq_ack[g] rising: 1 cycle.
- Handshake rules:
  - lnk_pkt is stable from lnk_req rise until lnk_ack falls.
  - At most one rq_ack bit is high at any time.
  - rq_ack[i] rises only while rq_req[i] is high.
- Simultaneous requests in IDLE: rotating priority. The last granted requester has lowest priority on the next pick.
- TOT_PKS=1: each packet is a full message; the arbiter re-arbitrates after every packet.
- Counter arithmetic: cnt is unsigned CW bits and never exceeds TOT_PKS (it is cleared on every grant).
- Requester drops rq_req in ARM before the next packet: the grant stays held (no timeout).
- Reset asserted mid-message: immediate return to the reset values above. The in-flight packet is lost, and pakin must also be reset.
- lnk_ack high while in IDLE or ARM: ignored (protocol violation, no state change).

Test Plan:
- Reset low 3 cycles then high -> gch_ready=0 during reset, gch_ready=1 exactly 1 cycle after release; all acks and lnk_req at 0.
- NREQ=2, TOT_PKS=3, requester 0 alone sends packets 0xA1,0xA2,0xA3 -> lnk_pkt carries them in order; grant_idx=0 throughout; grant_vld falls after the 3rd rq_ack falls.
- Both requesters raise rq_req in the same cycle after reset -> requester 0 wins. Requester 1 gets no rq_ack until requester 0 completes 3 packets, then takes the grant.
- Requester 1 raises rq_req mid-message of requester 0 -> none of requester 1's packets appear on lnk_pkt until requester 0's message completes.
- Repeated continuous requests from both -> grant alternates 0,1,0,1 per message, never per packet.
- Assert reset while in WAIT_ACK with lnk_req=1 -> lnk_req, rq_ack and grant_vld drop asynchronously to 0. After release, arbitration restarts with requester 0 priority.
